// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: memop codes, FSM states
// and the access-size lane mask.
package dmem_pkg;

  localparam logic [2:0] MEMOP_LB      = 3'b000;
  localparam logic [2:0] MEMOP_LH      = 3'b001;
  localparam logic [2:0] MEMOP_LW      = 3'b010;
  localparam logic [2:0] MEMOP_LD      = 3'b011;
  localparam logic [2:0] MEMOP_LBU     = 3'b100;
  localparam logic [2:0] MEMOP_LHU     = 3'b101;
  localparam logic [2:0] MEMOP_LWU     = 3'b110;
  localparam logic [2:0] MEMOP_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Lane mask of an access at offset 0; the low two memop bits encode log2(size).
  function automatic logic [7:0] size_mask(input logic [2:0] memop);
    logic [7:0] m;
    case (memop[1:0])
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the load/store unit (master) and dmem_ctrl
// (slave).
interface dmem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_memop;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_memop, req_we, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_memop, req_we, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/mem_bytelane_ram.sv
// Byte-lane single-port RAM: per-byte write enables, registered read.
// One narrow array per lane so each maps onto a block RAM column.
module mem_bytelane_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32768
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [DATA_W/8-1:0]        be_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-1:0]   idx_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o
);
  for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we_i && be_i[gi]) mem_q[idx_i] <= wdata_i[gi*8 +: 8];
      if (re_i)             rd_q         <= mem_q[idx_i];
    end

    assign rdata_o[gi*8 +: 8] = rd_q;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// Load/store data-memory controller: one access per request handshake, error
// screening at acceptance, extended load data on a valid/ready response.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32768,
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_ctrl_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [2:0]        memop_q;
  logic              we_q, err_q;
  logic [OB-1:0]     off_q;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;

  logic              req_ready, resp_valid, accept;
  logic              misalign, out_of_range, bad_op, req_err;
  logic              ram_we, ram_re;
  logic [NB-1:0]     ram_be;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, rd_shift, load_data;

  always_comb begin
    misalign = 1'b0;
    case (bus.req_memop[1:0])
      2'd1:    misalign = bus.req_addr[0];
      2'd2:    misalign = |bus.req_addr[1:0];
      2'd3:    misalign = |bus.req_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end

  // Any bit above the word index means the address would alias, so reject it.
  assign out_of_range = |(bus.req_addr >> (OB + IW));
  assign bad_op = (bus.req_memop == MEMOP_ILLEGAL) ||
                  ((DATA_W == 32) && ((bus.req_memop == MEMOP_LD) ||
                                      (bus.req_memop == MEMOP_LWU)));
  assign req_err = misalign | out_of_range | bad_op;
  assign accept  = bus.req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      memop_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      off_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        memop_q <= bus.req_memop;
        we_q    <= bus.req_we;
        err_q   <= req_err;
        off_q   <= bus.req_addr[OB-1:0];
        idx_q   <= bus.req_addr[OB +: IW];
        wdata_q <= bus.req_wdata;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        ram_we  = we_q & ~err_q;
        ram_re  = ~we_q & ~err_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        req_ready  = bus.resp_ready;
        if (bus.resp_ready) state_d = bus.req_valid ? ST_ACCESS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ram_be    = NB'(size_mask(memop_q)) << off_q;
  assign ram_wdata = wdata_q << {off_q, 3'b000};
  assign rd_shift  = ram_rdata >> {off_q, 3'b000};

  always_comb begin
    case (memop_q)
      MEMOP_LB:  load_data = DATA_W'($signed(rd_shift[7:0]));
      MEMOP_LH:  load_data = DATA_W'($signed(rd_shift[15:0]));
      MEMOP_LW:  load_data = DATA_W'($signed(rd_shift[31:0]));
      MEMOP_LBU: load_data = DATA_W'(rd_shift[7:0]);
      MEMOP_LHU: load_data = DATA_W'(rd_shift[15:0]);
      MEMOP_LWU: load_data = DATA_W'(rd_shift[31:0]);
      default:   load_data = rd_shift;
    endcase
  end

  mem_bytelane_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .re_i    (ram_re),
    .idx_i   (idx_q),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_err   = resp_valid & err_q;
  assign bus.resp_data  = (resp_valid && !we_q && !err_q) ? load_data : '0;
endmodule
